// File: rtl/lsu_mem_if.sv
// Load/store unit front end: turns core load/store requests into
// word-aligned req/ack bus transactions and formats load results.
module lsu_mem_if #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOAD_EN,
  input  logic        STORE_EN,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] STORE_DATA,
  output logic [31:0] MEM_READ,
  output logic        STALL,
  output logic        MEM_ERR,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_BE,
  output logic [31:0] BUS_WDATA,
  input  logic [31:0] BUS_RDATA,
  input  logic        BUS_ACK
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] mem_read_q, mem_read_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        to_q, to_d;

  logic        req;
  logic        bad;
  logic        f3_ok;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  // Request decode, only meaningful while IDLE
  always_comb begin
    req   = LOAD_EN | STORE_EN;
    is_b  = (FUNCT3[1:0] == 2'b00);
    is_h  = (FUNCT3[1:0] == 2'b01);
    is_w  = (FUNCT3[1:0] == 2'b10);
    f3_ok = 1'b0;
    unique case (FUNCT3)
      3'b000, 3'b001, 3'b010,
      3'b100, 3'b101: f3_ok = 1'b1;
      default:        f3_ok = 1'b0;
    endcase
    bad = (LOAD_EN & STORE_EN)
        | ~f3_ok
        | (STORE_EN & FUNCT3[2])
        | (is_h & ADDR[0])
        | (is_w & (ADDR[1:0] != 2'b00));
  end

  always_comb begin
    req_be    = 4'b0000;
    req_wdata = 32'h0;
    unique case (1'b1)
      is_b: begin
        req_be    = 4'b0001 << ADDR[1:0];
        req_wdata = {4{STORE_DATA[7:0]}};
      end
      is_h: begin
        req_be    = ADDR[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{STORE_DATA[15:0]}};
      end
      is_w: begin
        req_be    = 4'b1111;
        req_wdata = STORE_DATA;
      end
      default: begin
        req_be    = 4'b0000;
        req_wdata = 32'h0;
      end
    endcase
    if (!STORE_EN) begin
      req_wdata = 32'h0;
    end
  end

  // Load formatting uses the offset/size captured at accept time
  always_comb begin
    ld_byte = 8'h00;
    unique case (off_q)
      2'd0:    ld_byte = BUS_RDATA[7:0];
      2'd1:    ld_byte = BUS_RDATA[15:8];
      2'd2:    ld_byte = BUS_RDATA[23:16];
      default: ld_byte = BUS_RDATA[31:24];
    endcase
    ld_half = off_q[1] ? BUS_RDATA[31:16] : BUS_RDATA[15:0];
    ld_fmt  = BUS_RDATA;
    unique case (f3_q)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'h0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'h0, ld_half};
      default: ld_fmt = BUS_RDATA;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    off_d       = off_q;
    f3_d        = f3_q;
    cnt_d       = cnt_q;
    to_d        = to_q;
    unique case (state_q)
      IDLE: begin
        if (req && !bad) begin
          bus_req_d   = 1'b1;
          bus_we_d    = STORE_EN;
          bus_addr_d  = {ADDR[31:2], 2'b00};
          bus_be_d    = req_be;
          bus_wdata_d = req_wdata;
          off_d       = ADDR[1:0];
          f3_d        = FUNCT3;
          cnt_d       = 8'd0;
          to_d        = 1'b0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (BUS_ACK) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            mem_read_d = ld_fmt;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_req_d  = 1'b0;
          mem_read_d = 32'h0;
          to_d       = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        cnt_d   = 8'd0;
        to_d    = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      mem_read_q  <= 32'h0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      cnt_q       <= 8'd0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
    end
  end

  // Stall covers the accept cycle and all of BUSY; DONE lets the core retire
  always_comb begin
    STALL   = 1'b0;
    MEM_ERR = 1'b0;
    if (!RST) begin
      STALL   = ((state_q == IDLE) & req & ~bad)
              | (state_q == BUSY);
      MEM_ERR = ((state_q == IDLE) & req & bad)
              | ((state_q == DONE) & to_q);
    end
  end

  assign MEM_READ  = mem_read_q;
  assign BUS_REQ   = bus_req_q;
  assign BUS_WE    = bus_we_q;
  assign BUS_ADDR  = bus_addr_q;
  assign BUS_BE    = bus_be_q;
  assign BUS_WDATA = bus_wdata_q;

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit between the datapath and a req/ack data-memory bus.
- Turns load/store requests into word-aligned bus transactions with byte enables and write-lane replication.
- Stalls the core until the bus acknowledges.
- Returns a sign- or zero-extended load result on MEM_READ, which feeds the register-writeback select mux.

Parameters:
TIMEOUT, 16, BUSY cycles without BUS_ACK before the transaction is aborted (legal range 1..255)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
LOAD_EN  input  1  current instruction is a load
STORE_EN  input  1  current instruction is a store
FUNCT3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ADDR  input  32  effective address (ALU_OUT)
STORE_DATA  input  32  rs2 value
MEM_READ  output  32  formatted load result, registered
STALL  output  1  freeze PC/register writes, combinational
MEM_ERR  output  1  one-cycle error pulse
BUS_REQ  output  1  bus request, registered
BUS_WE  output  1  1 = write
BUS_ADDR  output  32  {ADDR[31:2],2'b00}
BUS_BE  output  4  byte enables
BUS_WDATA  output  32  lane-replicated store data
BUS_RDATA  input  32  read data, valid with BUS_ACK
BUS_ACK  input  1  transaction complete, sampled at rising edge

Behaviour:
- Reset, async: state IDLE; MEM_READ=0; BUS_REQ=0, BUS_WE=0, BUS_ADDR=0, BUS_BE=0, BUS_WDATA=0; timeout counter=0. MEM_ERR=0 and STALL=0 while RST=1. A reset mid-transaction drops BUS_REQ immediately. A later BUS_ACK is ignored.
- Request checks, evaluated in IDLE:
  - req = LOAD_EN|STORE_EN.
  - bad when any of: both enables high; FUNCT3 not in {000,001,010,100,101}; store with FUNCT3 100/101; H/HU with ADDR[0]=1; W with ADDR[1:0]!=0.
- IDLE:
  - req & !bad: STALL=1. Next edge: latch BUS_ADDR, BUS_WE=STORE_EN, BUS_BE, BUS_WDATA, plus ADDR[1:0] and FUNCT3 internally. Set BUS_REQ=1, go BUSY.
  - req & bad: MEM_ERR=1 that cycle (combinational); STALL=0; no bus activity; MEM_READ unchanged; stay IDLE.
- BUSY:
  - STALL=1. Bus outputs are held stable; the counter increments each cycle.
  - BUS_ACK=1 at edge: BUS_REQ<=0. For a load, MEM_READ<=formatted BUS_RDATA; for a store, MEM_READ is unchanged. Go DONE.
  - Counter reaches TIMEOUT-1 without ack: BUS_REQ<=0, MEM_READ<=0, MEM_ERR pulses in the DONE cycle, go DONE.
- DONE:
  - STALL=0; the core retires the instruction this cycle.
  - Inputs are ignored (they still describe the retiring instruction).
  - Next edge goes to IDLE; counter cleared.
- BUS_ACK outside BUSY is ignored.
- Minimum latency: accept cycle + one BUSY cycle with ack = 2 stall cycles. MEM_READ is valid in DONE.
- Byte enables and write data:
  - SB: BE = 4'b0001<<ADDR[1:0]; WDATA = {4{STORE_DATA[7:0]}}.
  - SH: BE = ADDR[1] ? 1100 : 0011; WDATA = {2{STORE_DATA[15:0]}}.
  - SW: BE = 1111; WDATA = STORE_DATA.
  - Loads: BE per the same size rule, WDATA = 0.
- Load formatting uses the latched offset:
  - Byte = RDATA[8*off+:8]; B sign-extends, BU zero-extends.
  - Half = RDATA[16*off[1]+:16]; H sign-extends, HU zero-extends.
  - W passes RDATA through.

Test Plan:
- LW ADDR=0x1004, ack in first BUSY cycle, RDATA=0xDEADBEEF -> BUS_ADDR=0x1004, BE=1111, WE=0; STALL high 2 cycles; MEM_READ=0xDEADBEEF in DONE.
- LB ADDR=0x2003, RDATA=0x80112233 -> BE=1000, MEM_READ=0xFFFFFF80. LBU with same inputs -> MEM_READ=0x00000080.
- LHU ADDR=0x2002, RDATA=0xBEEF1234 -> MEM_READ=0x0000BEEF. LH -> 0xFFFFBEEF.
- SB ADDR=0x3001, STORE_DATA=0x000000A5, ack after 3 BUSY cycles -> BUS_BE=0010, WDATA=0xA5A5A5A5, WE=1; bus outputs stable 3 cycles; STALL high 4 cycles; MEM_READ unchanged.
- LW ADDR=0x1002 -> MEM_ERR=1 for one cycle, STALL=0, BUS_REQ stays 0. LOAD_EN=STORE_EN=1 -> same response.
- TIMEOUT=4, LW with no ack -> BUS_REQ high 4 cycles then low, MEM_ERR pulse in DONE, MEM_READ=0. Assert RST during BUSY -> BUS_REQ=0 immediately, state IDLE, late ack ignored.
